// File: rtl/o_ru_rst_seq_pkg.sv
// Shared types and defaults for the O-RU staged reset sequencer.
// The optional ready-timeout feature is enabled by defining O_RU_RST_SEQ_TIMEOUT_EN.
package o_ru_rst_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_HOLD     = 2'd0,
    SEQ_WAIT_ACK = 2'd1,
    SEQ_DONE     = 2'd2,
    SEQ_ERROR    = 2'd3
  } seq_state_e;

  localparam int DEF_NUM_STAGES     = 4;
  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_W          = 16;

  // Width of a stage index; never narrower than one bit.
  function automatic int cur_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/o_ru_rst_seq_cnt.sv
// Loadable down-counter with zero flag. It is shared between the per-stage
// hold interval and the ready-wait timeout, so it saturates at zero rather
// than wrapping.
module o_ru_rst_seq_cnt #(
  parameter int                     CNT_W   = 16,
  parameter logic [CNT_W-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Reset to RST_VAL, load on request, otherwise count down until zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/o_ru_rst_seq.sv
// O-RU staged reset sequencer: releases NUM_STAGES downstream resets one at
// a time, holding each for HOLD_CYCLES and waiting for that stage's ready
// acknowledge before moving on. Define O_RU_RST_SEQ_TIMEOUT_EN to add a
// per-stage ready timeout that raises a sticky seq_err and re-asserts all
// stage resets.
//
// Handshake: stage_rdy[k] is a level acknowledge sampled only while stage k
// is the stage in progress and its reset has been released; it is consumed on
// the first such edge it is high. No ready/valid back-pressure is involved.
module o_ru_rst_seq
  import o_ru_rst_seq_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             soft_rst_req,
  input  logic [NUM_STAGES-1:0]            stage_rdy,
  output logic [NUM_STAGES-1:0]            stage_rst,
  output logic [cur_w(NUM_STAGES)-1:0]     cur_stage,
  output logic                             seq_done,
  output logic                             seq_err,
  output seq_state_e                       dbg_state
);

  localparam int                CUR_W   = cur_w(NUM_STAGES);
  localparam logic [CNT_W-1:0]  HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  WAIT_LD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CUR_W-1:0]  LAST    = CUR_W'(NUM_STAGES - 1);

  seq_state_e             state_q, state_n;
  logic [NUM_STAGES-1:0]  rst_q, rst_n;
  logic [CUR_W-1:0]       cur_q, cur_n;
  logic                   done_q, done_n;
  logic                   cnt_load;
  logic [CNT_W-1:0]       cnt_val;
  logic [CNT_W-1:0]       cnt;
  logic                   cnt_zero;

  // One counter serves both the hold interval and the ready-wait timeout.
  // Loading the wait value is harmless when the timeout is compiled out.
  o_ru_rst_seq_cnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (HOLD_LD)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

`ifdef O_RU_RST_SEQ_TIMEOUT_EN
  logic err_q, err_n;
`endif

  // Next-state and next-output logic; soft restart overrides everything
  // except the synchronous rst handled in the register block.
  always_comb begin
    state_n  = state_q;
    rst_n    = rst_q;
    cur_n    = cur_q;
    done_n   = done_q;
    cnt_load = 1'b0;
    cnt_val  = HOLD_LD;
`ifdef O_RU_RST_SEQ_TIMEOUT_EN
    err_n    = err_q;
`endif
    if (soft_rst_req) begin
      state_n  = SEQ_HOLD;
      rst_n    = '1;
      cur_n    = '0;
      done_n   = 1'b0;
      cnt_load = 1'b1;
      cnt_val  = HOLD_LD;
`ifdef O_RU_RST_SEQ_TIMEOUT_EN
      err_n    = 1'b0;
`endif
    end else begin
      case (state_q)
        SEQ_HOLD: begin
          if (cnt_zero) begin
            rst_n[cur_q] = 1'b0;
            state_n      = SEQ_WAIT_ACK;
            cnt_load     = 1'b1;
            cnt_val      = WAIT_LD;
          end
        end
        SEQ_WAIT_ACK: begin
          if (stage_rdy[cur_q]) begin
            if (cur_q == LAST) begin
              done_n  = 1'b1;
              state_n = SEQ_DONE;
            end else begin
              cur_n    = cur_q + 1'b1;
              cnt_load = 1'b1;
              cnt_val  = HOLD_LD;
              state_n  = SEQ_HOLD;
            end
          end
`ifdef O_RU_RST_SEQ_TIMEOUT_EN
          else if (cnt_zero) begin
            err_n   = 1'b1;
            rst_n   = '1;
            state_n = SEQ_ERROR;
          end
`endif
        end
        SEQ_DONE: begin
          state_n = SEQ_DONE;
        end
`ifdef O_RU_RST_SEQ_TIMEOUT_EN
        SEQ_ERROR: begin
          state_n = SEQ_ERROR;
        end
`endif
        default: begin
          state_n = SEQ_HOLD;
        end
      endcase
    end
  end

  // State and registered outputs; rst aborts with every stage held in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_HOLD;
      rst_q   <= '1;
      cur_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      rst_q   <= rst_n;
      cur_q   <= cur_n;
      done_q  <= done_n;
    end
  end

`ifdef O_RU_RST_SEQ_TIMEOUT_EN
  // Sticky timeout flag, cleared only by rst or a soft restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_n;
    end
  end
  assign seq_err = err_q;
`else
  assign seq_err = 1'b0;
`endif

  assign stage_rst = rst_q;
  assign cur_stage = cur_q;
  assign seq_done  = done_q;
  assign dbg_state = state_q;

endmodule
